// File: rtl/hc595_driver_if.sv
// Upstream word/clear handshake between the system logic and hc595_driver.
// master = word producer, slave = the driver.
interface hc595_driver_if #(
  parameter int unsigned NBYTES = 1
);
  localparam int unsigned W = 8 * NBYTES;

  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         clr_req;
  logic         busy;
  logic         done;

  modport master (
    output din, din_valid, clr_req,
    input  din_ready, busy, done
  );

  modport slave (
    input  din, din_valid, clr_req,
    output din_ready, busy, done
  );
endinterface

// File: rtl/hc595_driver.sv
// Serialises a parallel word MSB-first into a chain of 74HC595 devices and latches it.
// Optional macro HC595_DRV_BLANK_EN blanks the chain outputs (g_n=1) while busy.
module hc595_driver #(
  parameter int unsigned NBYTES = 1,
  parameter int unsigned DIV    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  hc595_driver_if.slave    bus,
  output logic             si,
  output logic             sck,
  output logic             rck,
  output logic             sclr_n,
  output logic             g_n
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned BW = $clog2(W);
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH_LO,
    LATCH_HI,
    CLEAR
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [BW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [W-1:0]   sreg, sreg_nxt;
  logic           latched, latched_nxt;
  logic           si_nxt, sck_nxt, rck_nxt, sclr_n_nxt, g_n_nxt;
  logic           done_nxt, busy_nxt, ready_nxt;
  logic           phase_end;

  assign phase_end = (cnt == CW'(DIV - 1));

  // Next-state and next-output decode; every chain pin is a registered copy of it.
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    latched_nxt = latched;
    done_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
        end else if (bus.din_valid) begin
          state_nxt   = SHIFT_LO;
          sreg_nxt    = bus.din;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT_LO: begin
        if (phase_end) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_cnt == BW'(W - 1)) begin
            state_nxt = LATCH_LO;
          end else begin
            state_nxt   = SHIFT_LO;
            bit_cnt_nxt = bit_cnt + BW'(1);
            sreg_nxt    = {sreg[W-2:0], 1'b0};
          end
        end
      end
      LATCH_LO: begin
        if (phase_end) state_nxt = LATCH_HI;
      end
      LATCH_HI: begin
        if (phase_end) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          latched_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (phase_end) state_nxt = LATCH_LO;
      end
      default: state_nxt = IDLE;
    endcase

    // Divider restarts on every phase change so each phase lasts exactly DIV cycles.
    cnt_nxt = ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + CW'(1);

    // si tracks the shift register MSB, which only moves while sck is low.
    si_nxt     = sreg_nxt[W-1];
    sck_nxt    = (state_nxt == SHIFT_HI);
    rck_nxt    = (state_nxt == LATCH_HI);
    sclr_n_nxt = (state_nxt != CLEAR);
    busy_nxt   = (state_nxt != IDLE);
    ready_nxt  = (state_nxt == IDLE);
`ifdef HC595_DRV_BLANK_EN
    g_n_nxt    = busy_nxt | ~latched_nxt;
`else
    g_n_nxt    = ~latched_nxt;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      sreg          <= '0;
      latched       <= 1'b0;
      si            <= 1'b0;
      sck           <= 1'b0;
      rck           <= 1'b0;
      sclr_n        <= 1'b0;
      g_n           <= 1'b1;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.din_ready <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      sreg          <= sreg_nxt;
      latched       <= latched_nxt;
      si            <= si_nxt;
      sck           <= sck_nxt;
      rck           <= rck_nxt;
      sclr_n        <= sclr_n_nxt;
      g_n           <= g_n_nxt;
      bus.done      <= done_nxt;
      bus.busy      <= busy_nxt;
      bus.din_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: one 1-device/DIV=2 instance and one 2-device/DIV=1 instance,
// each feeding a behavioural 595 chain model.
module tb_hc595_driver;

  localparam int unsigned DIV_A = 2;
  localparam int unsigned W_A   = 8;
  localparam int unsigned DIV_B = 1;
  localparam int unsigned W_B   = 16;

  logic clk, rst_n;
  logic si_a, sck_a, rck_a, sclr_n_a, g_n_a;
  logic si_b, sck_b, rck_b, sclr_n_b, g_n_b;

  hc595_driver_if #(.NBYTES(1)) bus_a ();
  hc595_driver_if #(.NBYTES(2)) bus_b ();

  hc595_driver #(.NBYTES(1), .DIV(DIV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .si(si_a), .sck(sck_a), .rck(rck_a), .sclr_n(sclr_n_a), .g_n(g_n_a)
  );

  hc595_driver #(.NBYTES(2), .DIV(DIV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .si(si_b), .sck(sck_b), .rck(rck_b), .sclr_n(sclr_n_b), .g_n(g_n_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural 595 chains: shift on sck rise, async clear, latch on rck rise.
  logic [W_A-1:0] sr_a, q_a;
  logic [W_B-1:0] sr_b, q_b;
  always @(posedge sck_a or negedge sclr_n_a)
    if (!sclr_n_a) sr_a <= '0; else sr_a <= {sr_a[W_A-2:0], si_a};
  always @(posedge rck_a) q_a <= sr_a;
  always @(posedge sck_b or negedge sclr_n_b)
    if (!sclr_n_b) sr_b <= '0; else sr_b <= {sr_b[W_B-2:0], si_b};
  always @(posedge rck_b) q_b <= sr_b;

  int sck_rises_a = 0;
  always @(posedge sck_a) sck_rises_a <= sck_rises_a + 1;

  // Per-cycle protocol rules, tallied and compared once at the end.
  logic rst_q;
  bit   mon_en = 1'b0;
  bit   ever_a = 1'b0, ever_b = 1'b0;
  logic prev_si_a = 1'b0, prev_si_b = 1'b0;
  int   viol_a = 0, viol_b = 0;
  always @(posedge clk) rst_q <= rst_n;

  always @(negedge clk) begin
    logic ea, eb;
    if (mon_en) begin
      if (!rst_q) begin ever_a = 1'b0; ever_b = 1'b0; end
`ifdef HC595_DRV_BLANK_EN
      ea = bus_a.busy | ~(ever_a | bus_a.done);
      eb = bus_b.busy | ~(ever_b | bus_b.done);
`else
      ea = ~(ever_a | bus_a.done);
      eb = ~(ever_b | bus_b.done);
`endif
      if (sck_a && rck_a) viol_a++;
      if (sck_b && rck_b) viol_b++;
      if ((si_a !== prev_si_a) && sck_a) viol_a++;
      if ((si_b !== prev_si_b) && sck_b) viol_b++;
      if (g_n_a !== ea) viol_a++;
      if (g_n_b !== eb) viol_b++;
      if (bus_a.din_ready !== ~bus_a.busy) viol_a++;
      if (bus_b.din_ready !== ~bus_b.busy) viol_b++;
      if (bus_a.done) ever_a = 1'b1;
      if (bus_b.done) ever_b = 1'b1;
    end
    prev_si_a = si_a;
    prev_si_b = si_b;
  end

  // One transaction on instance A; measures busy length, sclr_n low time, done.
  task automatic txn_a(input bit clr, input logic [W_A-1:0] w, output int nbusy,
                       output int nclr, output bit got_done, output logic rdy, output logic gn);
    @(negedge clk);
    bus_a.din = w; bus_a.din_valid = 1'b1; bus_a.clr_req = clr;
    @(negedge clk);
    bus_a.din_valid = 1'b0; bus_a.clr_req = 1'b0; bus_a.din = W_A'($urandom);
    nbusy = 0; nclr = 0; got_done = 1'b0; rdy = 1'b0; gn = 1'bx;
    for (int i = 0; i < 400 && !got_done; i++) begin
      bus_a.clr_req = (i == 4);
      if (bus_a.busy) nbusy++;
      if (!sclr_n_a) nclr++;
      if (bus_a.done) begin got_done = 1'b1; rdy = bus_a.din_ready; gn = g_n_a; end
      else @(negedge clk);
    end
    bus_a.clr_req = 1'b0;
  endtask

  task automatic txn_b(input bit clr, input logic [W_B-1:0] w, output int nbusy,
                       output int nclr, output bit got_done);
    @(negedge clk);
    bus_b.din = w; bus_b.din_valid = 1'b1; bus_b.clr_req = clr;
    @(negedge clk);
    bus_b.din_valid = 1'b0; bus_b.clr_req = 1'b0; bus_b.din = W_B'($urandom);
    nbusy = 0; nclr = 0; got_done = 1'b0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      if (bus_b.busy) nbusy++;
      if (!sclr_n_b) nclr++;
      if (bus_b.done) got_done = 1'b1;
      else @(negedge clk);
    end
  endtask

  typedef struct {
    bit             clr;
    logic [W_A-1:0] din;
    logic [W_A-1:0] q;
    int             busy;
    int             nclr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nb, nc, base, ndone;
    bit   gd;
    logic rdy, gn;
    logic [W_A-1:0] wa;
    logic [W_B-1:0] wb;
    bit   c;

    tbl[0] = '{1'b0, 8'hA5, 8'hA5, 36, 0};
    tbl[1] = '{1'b1, 8'hFF, 8'h00, 6,  2};
    tbl[2] = '{1'b0, 8'h3C, 8'h3C, 36, 0};
    tbl[3] = '{1'b0, 8'hFF, 8'hFF, 36, 0};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 36, 0};
    tbl[5] = '{1'b1, 8'h5A, 8'h00, 6,  2};
    tbl[6] = '{1'b0, 8'h81, 8'h81, 36, 0};

    rst_n = 1'b0;
    bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.clr_req = 1'b0;
    bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.clr_req = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("rst_sclr_n", sclr_n_a, 0);
    chk("rst_g_n", g_n_a, 1);
    chk("rst_ready", bus_a.din_ready, 1);
    chk("rst_sck_rck", {sck_a, rck_a, sck_b, rck_b}, 0);
    chk("rst_busy_done", {bus_a.busy, bus_a.done, bus_b.busy, bus_b.done}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_sclr_n", {sclr_n_a, sclr_n_b}, 2'b11);
    chk("post_rst_g_n", {g_n_a, g_n_b}, 2'b11);

    // Table of data and clear transactions on the 1-device chain
    foreach (tbl[k]) begin
      txn_a(tbl[k].clr, tbl[k].din, nb, nc, gd, rdy, gn);
      chk($sformatf("tbl%0d_done", k), gd, 1);
      chk($sformatf("tbl%0d_busy", k), nb, tbl[k].busy);
      chk($sformatf("tbl%0d_sclr_low", k), nc, tbl[k].nclr);
      chk($sformatf("tbl%0d_q", k), q_a, tbl[k].q);
      chk($sformatf("tbl%0d_ready_at_done", k), rdy, 1);
      chk($sformatf("tbl%0d_g_n_at_done", k), gn, 0);
    end

    // Two-device chain, 16'h1234
    txn_b(1'b0, 16'h1234, nb, nc, gd);
    chk("b1234_done", gd, 1);
    chk("b1234_busy", nb, 34);
    chk("b1234_dev1", q_b[15:8], 8'h12);
    chk("b1234_dev0", q_b[7:0], 8'h34);

    // Random words on chain B against the chain model and latency formula
    for (int r = 0; r < 20; r++) begin
      wb = W_B'($urandom);
      txn_b(1'b0, wb, nb, nc, gd);
      chk($sformatf("randb%0d_done", r), gd, 1);
      chk($sformatf("randb%0d_busy", r), nb, 2*DIV_B*W_B + 2*DIV_B);
      chk($sformatf("randb%0d_q", r), q_b, wb);
    end

    // Random mix of words and clears on chain A
    for (int r = 0; r < 12; r++) begin
      wa = W_A'($urandom);
      c  = ($urandom_range(0, 3) == 0);
      txn_a(c, wa, nb, nc, gd, rdy, gn);
      chk($sformatf("randa%0d_busy", r), nb, c ? 3*DIV_A : 2*DIV_A*W_A + 2*DIV_A);
      chk($sformatf("randa%0d_q", r), q_a, c ? W_A'(0) : wa);
    end

    // Reset in the middle of a shift, after three sck rising edges
    base = sck_rises_a;
    @(negedge clk);
    bus_a.din = 8'hC3; bus_a.din_valid = 1'b1;
    @(negedge clk);
    bus_a.din_valid = 1'b0;
    for (int i = 0; i < 200 && sck_rises_a < base + 3; i++) @(negedge clk);
    chk("midrst_sck_edges", sck_rises_a - base, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus_a.busy, 0);
    chk("midrst_sck", sck_a, 0);
    chk("midrst_g_n", g_n_a, 1);
    chk("midrst_sclr_n", sclr_n_a, 0);
    chk("midrst_done", bus_a.done, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_a.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    txn_a(1'b0, 8'h0F, nb, nc, gd, rdy, gn);
    chk("after_rst_busy", nb, 36);
    chk("after_rst_q", q_a, 8'h0F);

    // Back-to-back words; per-cycle g_n rule covers both build variants
    txn_a(1'b0, 8'h96, nb, nc, gd, rdy, gn);
    chk("b2b0_q", q_a, 8'h96);
    txn_a(1'b0, 8'h69, nb, nc, gd, rdy, gn);
    chk("b2b1_q", q_a, 8'h69);
    chk("b2b1_g_n_gap", gn, 0);

    repeat (3) @(negedge clk);
    chk("protocol_a", viol_a, 0);
    chk("protocol_b", viol_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hc595_driver.md
Name: hc595_driver

Overview:
- Upstream controller for a chain of one or more 74HC595-style shift/latch registers.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first on si/sck.
- Pulses rck to move the shifted word into the storage latches, and owns the chain's sclr_n and g_n pins.
- Sits between the system-clock logic and the board-level 595 chain; all chain pins are registered outputs.

Parameters:
- NBYTES, 1, number of cascaded 8-bit 595 devices; word width W = 8*NBYTES.
- DIV, 2, system-clock cycles per sck/rck half-period; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  W  parallel word; din[W-1] is shifted first and ends in the far device's bit 7.
- din_valid  input  1  word offered.
- din_ready  output  1  high only in IDLE; transfer occurs on clk edge with din_valid & din_ready.
- clr_req  input  1  request to clear the chain, sampled in IDLE only.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when a data or clear transaction completes.
- si  output  1  serial data to the first 595.
- sck  output  1  shift clock to the 595 chain.
- rck  output  1  latch clock to the 595 chain.
- sclr_n  output  1  active-low shift-register clear to the chain.
- g_n  output  1  active-low output enable to the chain.

Behaviour:
- Reset values (rst_n low at clk edge): state IDLE, si=0, sck=0, rck=0, sclr_n=0, g_n=1, done=0, busy=0, shift reg=0, bit and divide counters=0.
  - The first edge with rst_n high sets sclr_n=1.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH_LO, LATCH_HI, CLEAR.
- IDLE:
  - din_ready=1, sck=0, rck=0.
  - clr_req=1 -> CLEAR. clr_req has priority over din_valid; din is not accepted that cycle.
  - Otherwise din_valid=1 -> capture din, bit count=0, si=din[W-1] -> SHIFT_LO.
- SHIFT_LO:
  - sck=0 for DIV cycles; si stable; then -> SHIFT_HI.
- SHIFT_HI:
  - sck=1 for DIV cycles; si unchanged, since the 595 samples on the sck rising edge.
  - At the end: if bit count=W-1 -> LATCH_LO.
  - Otherwise bit count+1, shift reg left by 1, si=next MSB -> SHIFT_LO.
- LATCH_LO:
  - sck=0, rck=0 for DIV cycles (storage setup) -> LATCH_HI.
- LATCH_HI:
  - rck=1 for DIV cycles, then rck=0, done=1 for one cycle -> IDLE.
- CLEAR:
  - sclr_n=0 for DIV cycles, then sclr_n=1 -> LATCH_LO. This latches all-zero outputs and ends with done.
- Latency:
  - Data transaction: busy for exactly 2*DIV*W + 2*DIV cycles.
  - Clear transaction: busy for exactly 3*DIV cycles.
  - done asserts on the cycle state returns to IDLE; din_ready is high the same cycle.
- g_n:
  - Held 1 from reset until the first LATCH_HI completes (data or clear); 0 thereafter.
  - Changes only when the chain outputs hold known data.
- Edge sequencing:
  - sck and rck are never high in the same cycle.
  - si changes only while sck=0.
- din, din_valid and clr_req are ignored while busy; no queuing.
- Reset mid-transaction:
  - Abandon the transaction; no done pulse.
  - All outputs return to reset values on that edge, including g_n=1.
  - The chain is re-cleared because sclr_n=0.
- Divide counter counts 0..DIV-1 and reloads at every state change; with DIV=1 each phase lasts one cycle.

Optional Feature:
- Macro: HC595_DRV_BLANK_EN.
- Defined: g_n is forced to 1 in every non-IDLE state, blanking the display during shift/latch. It returns to 0 on the cycle after LATCH_HI ends, provided a latch has ever completed.
- Undefined: g_n behaves as in Behaviour; outputs stay enabled during transfers.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> sclr_n=0 during reset and 1 one cycle after; g_n=1; din_ready=1; sck=rck=0.
- Single byte, NBYTES=1, DIV=2, din=8'hA5 -> 8 sck rising edges with si sampled 1,0,1,0,0,1,0,1. Then one rck pulse 2 cycles wide, done at cycle 36 after accept, g_n falls to 0; a 595 model's q reads 8'hA5.
- Two-device chain, NBYTES=2, DIV=1, din=16'h1234 -> 16 sck edges; device1 q=8'h12, device0 q=8'h34; busy exactly 34 cycles.
- Simultaneous clr_req=1 and din_valid=1 in IDLE -> CLEAR taken, din not accepted. sclr_n low 2 cycles, model q=8'h00, done after 6 cycles; the next din then accepted.
- Reset mid-shift after 3 sck edges -> next edge: state IDLE, sck=0, g_n=1, sclr_n=0, no done. A following word 8'h0F transfers correctly.
- With HC595_DRV_BLANK_EN defined, two back-to-back words -> g_n=1 throughout each busy period and 0 in the IDLE gap between them.
